// File: rtl/shift_pipe.sv
// Two-stage elastic barrel shifter: SLL, SRL, SRA, ROR.
// Stage 1 applies the coarse part of the amount (high bits), stage 2 the fine part (low SPLIT bits).
module shift_pipe #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHW = $clog2(WIDTH),
  localparam int unsigned SPLIT = SHW / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   sa,
  input  logic             var_sel,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  typedef enum logic [1:0] {OpSll, OpSrl, OpSra, OpRor} op_e;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  op_e              r_s1_op;
  logic [SPLIT-1:0] r_s1_fine;
  logic             r_s1_sign;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  op_e              w_op;
  logic [SHW-1:0]   w_amt;
  logic [SHW-1:0]   w_coarse;
  logic [WIDTH-1:0] w_fill1;
  logic [WIDTH-1:0] w_coarse_data;
  logic [WIDTH-1:0] w_fill2;
  logic [WIDTH-1:0] w_fine_data;
  logic             w_unused_b;

  // Only the low SHW bits of b select an amount; the rest is ignored by design.
  assign w_unused_b = ^b[WIDTH-1:SHW];

  // Handshake: stage 2 moves when empty or drained; stage 1 moves into a moving stage 2.
  always_comb begin
    w_s2_adv = !r_out_valid || out_ready;
    w_s1_adv = r_s1_valid && w_s2_adv;
    in_ready = !r_s1_valid || w_s1_adv;
    w_accept = in_valid && in_ready;
  end

  // Stage 1 datapath: select amount and apply the coarse (multiple of 2^SPLIT) shift.
  always_comb begin
    w_op          = op_e'(op);
    w_amt         = var_sel ? b[SHW-1:0] : sa;
    w_coarse      = {w_amt[SHW-1:SPLIT], {SPLIT{1'b0}}};
    w_fill1       = a[WIDTH-1] ? ~({WIDTH{1'b1}} >> w_coarse) : '0;
    w_coarse_data = a;
    unique case (w_op)
      OpSll:   w_coarse_data = a << w_coarse;
      OpSrl:   w_coarse_data = a >> w_coarse;
      OpSra:   w_coarse_data = (a >> w_coarse) | w_fill1;
      OpRor:   w_coarse_data = (a >> w_coarse) | (a << (WIDTH - w_coarse));
      default: w_coarse_data = a;
    endcase
  end

  // Stage 2 datapath: fine shift; SRA fill comes from the sign captured at acceptance.
  always_comb begin
    w_fill2     = r_s1_sign ? ~({WIDTH{1'b1}} >> r_s1_fine) : '0;
    w_fine_data = r_s1_data;
    unique case (r_s1_op)
      OpSll:   w_fine_data = r_s1_data << r_s1_fine;
      OpSrl:   w_fine_data = r_s1_data >> r_s1_fine;
      OpSra:   w_fine_data = (r_s1_data >> r_s1_fine) | w_fill2;
      OpRor:   w_fine_data = (r_s1_data >> r_s1_fine) | (r_s1_data << (WIDTH - r_s1_fine));
      default: w_fine_data = r_s1_data;
    endcase
  end

  // Stage 1 registers: valid follows in_valid whenever the stage can take a new entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_op    <= OpSll;
      r_s1_fine  <= '0;
      r_s1_sign  <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_data <= w_coarse_data;
        r_s1_op   <= w_op;
        r_s1_fine <= w_amt[SPLIT-1:0];
        r_s1_sign <= a[WIDTH-1];
      end
    end
  end

  // Stage 2 registers: hold result stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_zero      <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res  <= w_fine_data;
        r_zero <= (w_fine_data == '0);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign zero      = r_zero;

endmodule
